bank2rs_streamer: RTL and testbench
===================================

Name: bank2rs_streamer

Overview:
- Transmit side of the Bank2RS interface. Accepts one vertex-gather request at a time: node id, feature-bank base address and feature count.
- Reads the feature vector from the feature bank, two FVs per bank word, and streams it to the vertex reservation station.
- Stream framing: sos on the first beat, eos on the last, two FVs per beat.
- Launches a vector only while the RS reports RS_available. Once launched, a vector streams without bubbles, because the RS has no mid-vector backpressure.

Parameters:
- FV_SIZE, 16, bits per feature value.
- MAX_FV_NUM, 16, maximum FVs per vector (even, ≥4).
- NODE_ID_W, 10, node id width.
- ADDR_W, 10, bank word address width (one word = 2 FVs).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_node_id  in  NODE_ID_W  node id of the vector
- req_base_addr  in  ADDR_W  bank word address of FV[0..1]
- req_num_fv  in  $clog2(MAX_FV_NUM)+1  FV count
- mem_rd_en  out  1  bank read strobe
- mem_rd_addr  out  ADDR_W  bank read address
- mem_rd_data  in  2*FV_SIZE  bank data, valid the cycle after mem_rd_en; [FV_SIZE-1:0] = lane 0
- RS_available  in  1  RS can take a new vector (combinational from RS; low while sos is high)
- out_sos  out  1  first beat of vector
- out_eos  out  1  last beat of vector
- out_node_id  out  NODE_ID_W  node id, held for whole vector
- out_fv0  out  FV_SIZE  lane 0 FV (even index)
- out_fv1  out  FV_SIZE  lane 1 FV (odd index)
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse the cycle after the eos beat
- req_err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset is asynchronous and active-high. While reset is high, all outputs are 0 except req_ready, which is 0 during reset. The state goes to IDLE immediately. A stream in flight is abandoned with no eos, and no partial beat is emitted after release.
- All outputs are registered. There is no combinational path from RS_available to out_sos (the RS makes RS_available combinational on sos, so this avoids a loop).
- States: IDLE, WAIT_RS, STREAM, DRAIN.
- IDLE: req_ready=1.
  - On req_valid, the request is accepted and latched.
  - Legal request: req_num_fv even, 4 ≤ req_num_fv ≤ MAX_FV_NUM. Go to WAIT_RS with beats = req_num_fv/2.
  - Illegal request: req_err=1 in the next cycle and the state stays IDLE. No stream and no bank read.
- WAIT_RS: req_ready=0. If RS_available is sampled 1 at a clock edge, go to STREAM. Otherwise wait indefinitely.
- STREAM:
  - mem_rd_en=1 in every STREAM cycle. mem_rd_addr = base + k for read k = 0..beats-1, wrapping mod 2^ADDR_W.
  - The first read appears in the cycle right after the RS_available sample.
  - After the last read is issued, go to DRAIN.
- Beat output: data for read k is registered onto out_fv0/out_fv1 and appears exactly 2 cycles after read k is issued.
  - out_sos=1 on beat 0 only. out_eos=1 on beat beats-1 only. Beats are contiguous, one per cycle.
  - out_node_id holds the latched id on every beat.
  - Outside beats, out_sos, out_eos, out_fv0, out_fv1 and out_node_id are 0.
- sos and eos are never high in the same cycle, since the minimum vector is 2 beats (the RS needs distinct sos and eos beats).
- DRAIN: wait until the eos beat has been output. In the following cycle, pulse done=1 and return to IDLE. req_ready is 1 in that same cycle.
- RS_available is ignored in STREAM and DRAIN.
- Back-to-back operation: a request accepted on the done cycle proceeds to WAIT_RS normally. After the RS fires, it holds RS_available low until it has drained, and the streamer waits in WAIT_RS throughout.
- The beat counter is $clog2(MAX_FV_NUM/2)+1 bits wide. Address arithmetic is modulo 2^ADDR_W.

Test Plan:
- Minimum vector: node 5, base 0x010, num_fv 4, RS_available=1.
  - Reads at 0x010 then 0x011 in consecutive cycles.
  - 2 cycles after each read: sos beat with bank[0x010], then eos beat with bank[0x011], node_id 5 on both.
  - done pulses the next cycle.
- Full vector: num_fv 16, base 0x100.
  - 8 contiguous reads 0x100–0x107, followed by 8 contiguous beats.
  - sos only on beat 0, eos only on beat 7, no bubbles.
- RS backpressure: hold RS_available=0 for 20 cycles after accept. No mem_rd_en and no sos during that time, busy=1.
- RS_available drop mid-stream: raise RS_available for one cycle, then drop it during STREAM. The stream completes unaffected.
- Illegal requests: num_fv 3, 2, and MAX_FV_NUM+2.
  - Each gives a req_err pulse one cycle after accept and zero mem_rd_en.
  - A following legal request streams normally.
- Address wrap and reset:
  - base 2^ADDR_W-1, num_fv 6: reads at 0x3FF, 0x000, 0x001.
  - Assert reset asynchronously between beats 1 and 2 of an 8-beat vector. All outputs are 0 in the same cycle, no eos is produced, and after release a new request streams correctly.

Source files
------------

// File: rtl/bank2rs_streamer_if.sv
// Bank2RS transmit-side bundle: gather request, feature-bank read port and RS stream.
// master is the streamer; slave is the request source / bank / RS side.
interface bank2rs_streamer_if #(
   parameter int FV_SIZE    = 16,
   parameter int MAX_FV_NUM = 16,
   parameter int NODE_ID_W  = 10,
   parameter int ADDR_W     = 10
);
   localparam int NUM_W = $clog2(MAX_FV_NUM) + 1;

   logic                   req_valid;
   logic                   req_ready;
   logic [NODE_ID_W-1:0]   req_node_id;
   logic [ADDR_W-1:0]      req_base_addr;
   logic [NUM_W-1:0]       req_num_fv;

   logic                   mem_rd_en;
   logic [ADDR_W-1:0]      mem_rd_addr;
   logic [2*FV_SIZE-1:0]   mem_rd_data;

   logic                   RS_available;
   logic                   out_sos;
   logic                   out_eos;
   logic [NODE_ID_W-1:0]   out_node_id;
   logic [FV_SIZE-1:0]     out_fv0;
   logic [FV_SIZE-1:0]     out_fv1;

   logic                   busy;
   logic                   done;
   logic                   req_err;

   modport master (
      input  req_valid, req_node_id, req_base_addr, req_num_fv, mem_rd_data, RS_available,
      output req_ready, mem_rd_en, mem_rd_addr, out_sos, out_eos, out_node_id, out_fv0, out_fv1,
             busy, done, req_err
   );

   modport slave (
      output req_valid, req_node_id, req_base_addr, req_num_fv, mem_rd_data, RS_available,
      input  req_ready, mem_rd_en, mem_rd_addr, out_sos, out_eos, out_node_id, out_fv0, out_fv1,
             busy, done, req_err
   );
endinterface

// File: rtl/bank2rs_streamer.sv
// Bank2RS transmit side: gathers one feature vector from the bank (2 FVs/word) and
// streams it to the vertex RS with sos/eos framing once the RS reports availability.
module bank2rs_streamer #(
   parameter int FV_SIZE    = 16,
   parameter int MAX_FV_NUM = 16,
   parameter int NODE_ID_W  = 10,
   parameter int ADDR_W     = 10
) (
   input logic                clk,
   input logic                reset,
   bank2rs_streamer_if.master bus
);
   localparam int NUM_W  = $clog2(MAX_FV_NUM) + 1;
   localparam int BEAT_W = $clog2(MAX_FV_NUM / 2) + 1;

   typedef enum logic [1:0] {IDLE, WAIT_RS, STREAM, DRAIN} state_t;

   state_t               state_reg;
   logic                 req_ready_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic                 req_err_reg;
   logic [NODE_ID_W-1:0] node_id_reg;
   logic [ADDR_W-1:0]    rd_addr_reg;
   logic [BEAT_W-1:0]    beats_reg;
   logic [BEAT_W-1:0]    rd_cnt_reg;
   logic                 rd_en_reg;
   logic                 rd_first_reg;
   logic                 rd_last_reg;

   logic                 dat_valid_reg;
   logic                 dat_first_reg;
   logic                 dat_last_reg;
   logic                 out_sos_reg;
   logic                 out_eos_reg;
   logic [NODE_ID_W-1:0] out_node_id_reg;
   logic [2*FV_SIZE-1:0] out_data_reg;

   logic                 req_legal;
   logic [BEAT_W-1:0]    req_beats;

   always_comb begin
      req_legal = (bus.req_num_fv[0] == 1'b0)
               && (bus.req_num_fv >= NUM_W'(4))
               && (bus.req_num_fv <= NUM_W'(MAX_FV_NUM));
      req_beats = BEAT_W'(bus.req_num_fv >> 1);
   end

   // Control FSM; the read address register doubles as the bank address output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         req_ready_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         req_err_reg   <= 1'b0;
         node_id_reg   <= '0;
         rd_addr_reg   <= '0;
         beats_reg     <= '0;
         rd_cnt_reg    <= '0;
         rd_en_reg     <= 1'b0;
         rd_first_reg  <= 1'b0;
         rd_last_reg   <= 1'b0;
      end else begin
         done_reg     <= 1'b0;
         req_err_reg  <= 1'b0;
         rd_en_reg    <= 1'b0;
         rd_first_reg <= 1'b0;
         rd_last_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               req_ready_reg <= 1'b1;
               busy_reg      <= 1'b0;
               if (bus.req_valid && req_ready_reg) begin
                  if (req_legal) begin
                     state_reg     <= WAIT_RS;
                     req_ready_reg <= 1'b0;
                     busy_reg      <= 1'b1;
                     node_id_reg   <= bus.req_node_id;
                     rd_addr_reg   <= bus.req_base_addr;
                     beats_reg     <= req_beats;
                  end else begin
                     req_err_reg <= 1'b1;
                  end
               end
            end
            WAIT_RS: begin
               if (bus.RS_available) begin
                  state_reg    <= STREAM;
                  rd_en_reg    <= 1'b1;
                  rd_first_reg <= 1'b1;
                  rd_cnt_reg   <= BEAT_W'(1);
               end
            end
            STREAM: begin
               if (rd_cnt_reg == beats_reg) begin
                  state_reg <= DRAIN;
               end else begin
                  rd_en_reg   <= 1'b1;
                  rd_addr_reg <= rd_addr_reg + 1'b1;
                  rd_cnt_reg  <= rd_cnt_reg + 1'b1;
                  rd_last_reg <= ((rd_cnt_reg + 1'b1) == beats_reg);
               end
            end
            DRAIN: begin
               if (out_eos_reg) begin
                  state_reg     <= IDLE;
                  done_reg      <= 1'b1;
                  busy_reg      <= 1'b0;
                  req_ready_reg <= 1'b1;
               end
            end
         endcase
      end
   end

   // Two-stage beat pipeline: bank latency, then output register; zero outside beats.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dat_valid_reg   <= 1'b0;
         dat_first_reg   <= 1'b0;
         dat_last_reg    <= 1'b0;
         out_sos_reg     <= 1'b0;
         out_eos_reg     <= 1'b0;
         out_node_id_reg <= '0;
         out_data_reg    <= '0;
      end else begin
         dat_valid_reg   <= rd_en_reg;
         dat_first_reg   <= rd_en_reg & rd_first_reg;
         dat_last_reg    <= rd_en_reg & rd_last_reg;
         out_sos_reg     <= dat_valid_reg & dat_first_reg;
         out_eos_reg     <= dat_valid_reg & dat_last_reg;
         out_node_id_reg <= dat_valid_reg ? node_id_reg : '0;
         out_data_reg    <= dat_valid_reg ? bus.mem_rd_data : '0;
      end
   end

   assign bus.req_ready   = req_ready_reg;
   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.req_err     = req_err_reg;
   assign bus.mem_rd_en   = rd_en_reg;
   assign bus.mem_rd_addr = rd_addr_reg;
   assign bus.out_sos     = out_sos_reg;
   assign bus.out_eos     = out_eos_reg;
   assign bus.out_node_id = out_node_id_reg;
   assign bus.out_fv0     = out_data_reg[FV_SIZE-1:0];
   assign bus.out_fv1     = out_data_reg[2*FV_SIZE-1:FV_SIZE];
endmodule

// File: tb/tb_bank2rs_streamer.sv
// Directed bench for bank2rs_streamer: a small bank model answers reads one cycle
// later and every stream is checked cycle by cycle against the expected framing.
module tb_bank2rs_streamer;
   localparam int FV_SIZE    = 16;
   localparam int MAX_FV_NUM = 16;
   localparam int NODE_ID_W  = 10;
   localparam int ADDR_W     = 10;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   bank2rs_streamer_if #(.FV_SIZE(FV_SIZE), .MAX_FV_NUM(MAX_FV_NUM),
                         .NODE_ID_W(NODE_ID_W), .ADDR_W(ADDR_W)) bus ();

   bank2rs_streamer #(.FV_SIZE(FV_SIZE), .MAX_FV_NUM(MAX_FV_NUM),
                      .NODE_ID_W(NODE_ID_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Bank word at address a: lane0 = 0x1000+a, lane1 = 0x8000+a.
   function automatic logic [31:0] bank_word(input logic [ADDR_W-1:0] a);
      logic [15:0] lo;
      logic [15:0] hi;
      lo = 16'h1000 + {6'h0, a};
      hi = 16'h8000 + {6'h0, a};
      return {hi, lo};
   endfunction

   // Registered-read bank; garbage when not read so ungated data shows up.
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= bank_word(bus.mem_rd_addr);
      else               bus.mem_rd_data <= 32'hDEAD_BEEF;
   end

   logic [58:0] all_out;
   assign all_out = {bus.req_ready, bus.busy, bus.done, bus.req_err, bus.mem_rd_en,
                     bus.mem_rd_addr, bus.out_sos, bus.out_eos, bus.out_node_id,
                     bus.out_fv0, bus.out_fv1};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [NODE_ID_W-1:0] node, input logic [ADDR_W-1:0] base,
                           input logic [4:0] num);
      bus.req_node_id   = node;
      bus.req_base_addr = base;
      bus.req_num_fv    = num;
      bus.req_valid     = 1'b1;
      tick();
      bus.req_valid     = 1'b0;
      $display("req node=%0h base=%0h num_fv=%0d", node, base, num);
   endtask

   task automatic post_accept(input string tag);
      check(tag, {bus.req_ready, bus.busy, bus.mem_rd_en, bus.req_err, bus.out_sos}, 5'b01000);
   endtask

   // Called in the cycle where read 0 is visible; ends one cycle after the done pulse.
   task automatic expect_stream(input logic [NODE_ID_W-1:0] node, input logic [ADDR_W-1:0] base,
                                input int beats);
      for (int i = 0; i <= beats + 2; i++) begin
         int               b;
         logic [ADDR_W-1:0] a_exp;
         logic [4:0]       frm_exp;
         logic [41:0]      dat_exp;
         b       = i - 2;
         a_exp   = base + ADDR_W'(i);
         frm_exp = {b == 0, b == beats - 1, i == beats + 2, i < beats + 2, i == beats + 2};
         if (i < beats)
            check($sformatf("rd_%0h_c%0d", base, i), {bus.mem_rd_en, bus.mem_rd_addr}, {1'b1, a_exp});
         else
            check($sformatf("rd_off_%0h_c%0d", base, i), bus.mem_rd_en, 1'b0);
         check($sformatf("frame_%0h_c%0d", base, i),
               {bus.out_sos, bus.out_eos, bus.done, bus.busy, bus.req_ready}, frm_exp);
         dat_exp = '0;
         if (b >= 0 && b < beats) begin
            a_exp   = base + ADDR_W'(b);
            dat_exp = {node, bank_word(a_exp)};
         end
         check($sformatf("data_%0h_c%0d", base, i), {bus.out_node_id, bus.out_fv1, bus.out_fv0}, dat_exp);
         tick();
      end
      $display("stream node=%0h base=%0h beats=%0d checked", node, base, beats);
   endtask

   int bad_num [3] = '{3, 2, MAX_FV_NUM + 2};

   initial begin
      reset             = 1'b1;
      bus.req_valid     = 1'b0;
      bus.req_node_id   = '0;
      bus.req_base_addr = '0;
      bus.req_num_fv    = '0;
      bus.RS_available  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", all_out, '0);
      reset = 1'b0;
      #1;
      check("release_ready_low", bus.req_ready, 1'b0);
      tick();
      check("idle_ready", {bus.req_ready, bus.busy}, 2'b10);

      // Minimum vector
      bus.RS_available = 1'b1;
      send_req(10'h005, 10'h010, 5'd4);
      post_accept("min_accept");
      tick();
      expect_stream(10'h005, 10'h010, 2);

      // Full vector
      send_req(10'h3AB, 10'h100, 5'd16);
      post_accept("full_accept");
      tick();
      expect_stream(10'h3AB, 10'h100, 8);

      // RS backpressure then a one-cycle availability window
      bus.RS_available = 1'b0;
      send_req(10'h02C, 10'h200, 5'd8);
      for (int k = 0; k < 20; k++) begin
         check($sformatf("bp_c%0d", k), {bus.mem_rd_en, bus.out_sos, bus.busy}, 3'b001);
         tick();
      end
      $display("backpressure 20 cycles checked");
      bus.RS_available = 1'b1;
      tick();
      bus.RS_available = 1'b0;
      expect_stream(10'h02C, 10'h200, 4);

      // Illegal requests
      bus.RS_available = 1'b1;
      for (int k = 0; k < 3; k++) begin
         logic [4:0] n;
         n = 5'(bad_num[k]);
         send_req(10'h001, 10'h030, n);
         check($sformatf("err_pulse_n%0d", n), {bus.req_err, bus.busy, bus.mem_rd_en, bus.req_ready}, 4'b1001);
         tick();
         check($sformatf("err_clear_n%0d", n), {bus.req_err, bus.busy, bus.mem_rd_en}, 3'b000);
         tick();
         check($sformatf("err_noread_n%0d", n), {bus.mem_rd_en, bus.out_sos}, 2'b00);
      end
      send_req(10'h007, 10'h020, 5'd4);
      post_accept("after_err_accept");
      tick();
      expect_stream(10'h007, 10'h020, 2);

      // Address wrap
      send_req(10'h155, 10'h3FF, 5'd6);
      post_accept("wrap_accept");
      tick();
      expect_stream(10'h155, 10'h3FF, 3);

      // Asynchronous reset between beats 1 and 2
      send_req(10'h009, 10'h050, 5'd16);
      post_accept("rst_accept");
      tick();
      tick();
      tick();
      check("rst_beat0_sos", {bus.out_sos, bus.out_eos}, 2'b10);
      tick();
      check("rst_beat1", {bus.out_sos, bus.out_eos, bus.out_node_id, bus.out_fv1, bus.out_fv0},
            {2'b00, 10'h009, bank_word(10'h051)});
      #3 reset = 1'b1;
      #1;
      check("rst_async_zero", all_out, '0);
      @(posedge clk);
      #1;
      check("rst_held_zero", all_out, '0);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         check($sformatf("post_rst_c%0d", k),
               {bus.out_sos, bus.out_eos, bus.mem_rd_en, bus.done, bus.busy}, 5'b00000);
         tick();
      end
      $display("reset mid-stream: no eos after release");
      send_req(10'h1FF, 10'h3F0, 5'd8);
      post_accept("post_rst_accept");
      tick();
      expect_stream(10'h1FF, 10'h3F0, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
